// File: rtl/instruction_fetch_pkg.sv
// Shared widths, opcode field placement and fetch FSM states for the instruction fetch unit.
package instruction_fetch_pkg;

  localparam int unsigned DefPcW   = 12;
  localparam int unsigned DefInstW = 19;
  localparam int unsigned DefOffW  = 8;
  // Opcode occupies the top OpcW bits of the instruction word.
  localparam int unsigned OpcW     = 6;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_fetch_buffer.sv
// Two-entry instruction/PC FIFO with a registered head word and a flush that overrides push.
module fetch_buffer #(
  parameter int unsigned Width = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      rd_ptr_d = rd_ptr_q ^ do_pop;
      wr_ptr_d = wr_ptr_q ^ do_push;
      count_d  = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory reads into a 2-entry buffer, with branch redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned PC_W   = DefPcW,
  parameter int unsigned INST_W = DefInstW,
  parameter int unsigned OFF_W  = DefOffW
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic              redirect_sel_const_i,
  input  logic              redirect_sel_offset_i,
  input  logic [PC_W-1:0]   redirect_base_pc_i,
  input  logic [OFF_W-1:0]  redirect_offset_i,
  input  logic [PC_W-1:0]   redirect_target_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_data_o,
  output logic [OpcW-1:0]   inst_opcode_o,
  output logic [PC_W-1:0]   inst_pc_o
);

  localparam int unsigned ExtW = PC_W - OFF_W;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] seq_pc, target;
  logic            push, pop;
  logic [1:0]      count;

  always_comb begin
    seq_pc = redirect_base_pc_i + PC_W'(1);
    if (redirect_sel_const_i) begin
      target = redirect_target_i;
    end else if (redirect_sel_offset_i) begin
      target = seq_pc + {{ExtW{redirect_offset_i[OFF_W-1]}}, redirect_offset_i};
    end else begin
      target = seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      fetch_pc_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (redirect_valid_i) begin
          fetch_pc_d = target;
        end else if (count < 2'd2) begin
          state_d = StWait;
          addr_d  = fetch_pc_q;
        end
      end
      StWait: begin
        if (imem_ack_i && redirect_valid_i) begin
          // Acked word is stale; the flushed buffer has room, so reissue at once.
          addr_d     = target;
          fetch_pc_d = target;
        end else if (imem_ack_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_W'(1);
          state_d    = StFetch;
        end else if (redirect_valid_i) begin
          fetch_pc_d = target;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (redirect_valid_i) fetch_pc_d = target;
        if (imem_ack_i) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    imem_req_o  = (state_q != StFetch);
    imem_addr_o = addr_q;
  end

  assign pop = inst_valid_o && inst_ready_i;

  fetch_buffer #(
    .Width(INST_W + PC_W)
  ) u_fetch_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_valid_i),
    .wdata_i({imem_rdata_i, addr_q}),
    .rdata_o({inst_data_o, inst_pc_o}),
    .valid_o(inst_valid_o),
    .count_o(count)
  );

  assign inst_opcode_o = inst_data_o[INST_W-1 -: OpcW];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for redirect targets plus hand sequences.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic        redirect_sel_const = 1'b0;
  logic        redirect_sel_offset = 1'b0;
  logic [11:0] redirect_base_pc = '0;
  logic [7:0]  redirect_offset = '0;
  logic [11:0] redirect_target = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [18:0] inst_data;
  logic [5:0]  inst_opcode;
  logic [11:0] inst_pc;

  int checks = 0;
  int errors = 0;
  int lat = 0;

  instruction_fetch dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .imem_req_o           (imem_req),
    .imem_addr_o          (imem_addr),
    .imem_ack_i           (imem_ack),
    .imem_rdata_i         (imem_rdata),
    .redirect_valid_i     (redirect_valid),
    .redirect_sel_const_i (redirect_sel_const),
    .redirect_sel_offset_i(redirect_sel_offset),
    .redirect_base_pc_i   (redirect_base_pc),
    .redirect_offset_i    (redirect_offset),
    .redirect_target_i    (redirect_target),
    .inst_valid_o         (inst_valid),
    .inst_ready_i         (inst_ready),
    .inst_data_o          (inst_data),
    .inst_opcode_o        (inst_opcode),
    .inst_pc_o            (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] word(input logic [11:0] a);
    logic [5:0] op;
    op = (a < 12'd3) ? 6'd0 : (a[5:0] ^ 6'h2A);
    return {op, 13'(a + 12'd1)};
  endfunction

  // Memory model: acks `lat` cycles after a request becomes visible.
  initial begin
    int  cnt;
    logic prev;
    cnt = 0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      prev = imem_ack;
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        cnt = 0;
      end else begin
        if (prev) cnt = 0;
        if (cnt >= lat) begin
          imem_ack = 1'b1;
          imem_rdata = word(imem_addr);
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_outs", {imem_addr, inst_pc, 7'd0, inst_valid}, 32'd0);
    chk("rst_data", 32'(inst_data), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  // sel 0: wait for imem_req, sel 1: wait for imem_ack; timeout counts as a failure.
  task automatic wait_for(input int sel, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ((sel == 0 && imem_req) || (sel == 1 && imem_ack)) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
    end
  endtask

  task automatic redirect(input logic c, input logic o, input logic [11:0] base,
                          input logic [7:0] off, input logic [11:0] tgt);
    redirect_valid = 1'b1;
    redirect_sel_const = c;
    redirect_sel_offset = o;
    redirect_base_pc = base;
    redirect_offset = off;
    redirect_target = tgt;
    tick();
    redirect_valid = 1'b0;
  endtask

  typedef struct {
    logic        sel_const;
    logic        sel_offset;
    logic [11:0] base;
    logic [7:0]  off;
    logic [11:0] tgt;
    int          pre;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 12'h010, 8'hFE, 12'h000, 0, 12'h00F};
    vecs[1] = '{1'b0, 1'b1, 12'hFFF, 8'h01, 12'h000, 1, 12'h001};
    vecs[2] = '{1'b1, 1'b1, 12'h100, 8'h05, 12'h123, 2, 12'h123};
    vecs[3] = '{1'b0, 1'b0, 12'h0FF, 8'h7F, 12'h555, 3, 12'h100};
    vecs[4] = '{1'b0, 1'b0, 12'hFFF, 8'h10, 12'h321, 1, 12'h000};
    vecs[5] = '{1'b0, 1'b1, 12'h080, 8'h80, 12'h000, 0, 12'h001};
    vecs[6] = '{1'b0, 1'b1, 12'h7F0, 8'h7F, 12'h000, 2, 12'h870};
    vecs[7] = '{1'b1, 1'b0, 12'h000, 8'h00, 12'hABC, 3, 12'hABC};

    // Zero-wait stream with a consumer that is always ready.
    lat = 0;
    inst_ready = 1'b1;
    #2;
    do_reset();
    tick();
    chk("first_req", {imem_req, 19'd0, imem_addr}, {1'b1, 31'd0});
    for (int k = 0; k < 3; k++) begin
      wait_for(1, "stream_ack");
      tick();
      chk("stream_valid", 32'(inst_valid), 32'd1);
      chk("stream_pc", 32'(inst_pc), 32'(k));
      chk("stream_data", 32'(inst_data), 32'(k + 1));
    end

    // Backpressure: buffer fills with two words and fetching stops.
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_req", 32'(imem_req), 32'd0);
      chk("bp_head", {inst_valid, 7'd0, inst_pc, 12'd0}, {1'b1, 7'd0, 12'h000, 12'd0});
      chk("bp_data", 32'(inst_data), 32'h1);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    chk("bp_second", {inst_valid, 19'd0, inst_pc}, {1'b1, 19'd0, 12'h001});
    chk("bp_second_data", 32'(inst_data), 32'h2);
    tick();
    chk("bp_empty", 32'(inst_valid), 32'd0);
    chk("bp_resume", {imem_req, 19'd0, imem_addr}, {1'b1, 19'd0, 12'h002});

    // Redirect target table, applied with the FSM in FETCH or WAIT+ack.
    for (int v = 0; v < 8; v++) begin
      lat = 0;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < vecs[v].pre; i++) tick();
      redirect(vecs[v].sel_const, vecs[v].sel_offset, vecs[v].base, vecs[v].off, vecs[v].tgt);
      chk($sformatf("vec%0d_flush", v), 32'(inst_valid), 32'd0);
      wait_for(0, "vec_req");
      chk($sformatf("vec%0d_addr", v), 32'(imem_addr), 32'(vecs[v].exp_addr));
      wait_for(1, "vec_ack");
      tick();
      chk($sformatf("vec%0d_pc", v), {inst_valid, 19'd0, inst_pc}, {1'b1, 19'd0, vecs[v].exp_addr});
    end

    // Redirect while waiting on a slow read: drain it and discard the word.
    lat = 3;
    do_reset();
    tick();
    redirect(1'b1, 1'b0, 12'h000, 8'h00, 12'h123);
    for (int i = 0; i < 10; i++) begin
      if (imem_ack) break;
      chk("drain_hold", {imem_req, inst_valid, 18'd0, imem_addr}, {1'b1, 31'd0});
      tick();
    end
    chk("drain_acked", 32'(imem_ack), 32'd1);
    tick();
    chk("drain_discard", {imem_req, inst_valid}, 32'd0);
    wait_for(0, "drain_req");
    chk("drain_target", 32'(imem_addr), 32'h123);
    wait_for(1, "drain_ack");
    tick();
    chk("drain_pc", {inst_valid, 19'd0, inst_pc}, {1'b1, 19'd0, 12'h123});
    chk("drain_data", 32'(inst_data), 32'(word(12'h123)));

    // Redirect coinciding with ack: no drain cycle.
    lat = 0;
    do_reset();
    tick();
    chk("same_ack_pre", 32'(imem_ack), 32'd1);
    redirect(1'b1, 1'b0, 12'h000, 8'h00, 12'h2A0);
    chk("same_req", {imem_req, inst_valid, 18'd0, imem_addr}, {2'b10, 18'd0, 12'h2A0});
    tick();
    chk("same_pc", {inst_valid, 19'd0, inst_pc}, {1'b1, 19'd0, 12'h2A0});
    chk("same_opcode", 32'(inst_opcode), 32'h0A);

    // Asynchronous reset in the middle of a WAIT.
    lat = 3;
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    chk("async_pre", {imem_req, inst_valid, 18'd0, imem_addr}, {2'b11, 18'd0, 12'h001});
    rst_n = 1'b0;
    #1;
    chk("async_req", {imem_req, inst_valid}, 32'd0);
    chk("async_addr_pc", {8'd0, imem_addr, inst_pc}, 32'd0);
    chk("async_data", {7'd0, inst_opcode, inst_data}, 32'd0);
    #1;
    rst_n = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk("async_restart", {imem_req, 19'd0, imem_addr}, {1'b1, 31'd0});
    wait_for(1, "async_ack");
    tick();
    chk("async_word", {inst_valid, 19'd0, inst_pc}, {1'b1, 31'd0});
    chk("async_word_data", 32'(inst_data), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
